// File: rtl/data_mem_port_if.sv
// External 16-bit data bus between the load/store controller and memory:
// the controller drives a req/we/addr/wdata request; memory answers with a one-cycle ack plus rdata.
interface data_mem_port_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/data_mem_port.sv
// Load/store bus controller after the memory stage: one word request per instruction, req/ack bus
// handshake with a timeout abort, and a pipeline stall while a transaction is outstanding.
// Optional DMP_POSTED_WRITE_EN: stores go into a one-entry write buffer without stalling the pipeline.
module data_mem_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  data_mem_port_if.master   bus
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              latch_req;
  logic              finish;
  logic              finish_err;
  logic              stall_c;

`ifdef DMP_POSTED_WRITE_EN
  logic              posted_q;
  logic              err_sticky_q;
`endif

  // Wait counter never wraps, so a stuck count can't re-arm the timeout compare.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    latch_req  = 1'b0;
    finish     = 1'b0;
    finish_err = 1'b0;
    stall_c    = 1'b0;
    case (state)
      IDLE: begin
        stall_c = req_valid;
`ifdef DMP_POSTED_WRITE_EN
        if (req_valid && req_write) stall_c = 1'b0;
`endif
        if (req_valid) begin
          latch_req = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = BUS;
        end
      end
      BUS: begin
        stall_c = 1'b1;
`ifdef DMP_POSTED_WRITE_EN
        if (posted_q) stall_c = req_valid;
`endif
        if (bus.bus_ack) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      DONE: begin
        // The pipeline advances this cycle; a new request is only taken back in IDLE.
        stall_c = 1'b0;
`ifdef DMP_POSTED_WRITE_EN
        if (posted_q) stall_c = req_valid;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      wr_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch_req) begin
        wr_p0    <= req_write;
        addr_p0  <= req_addr;
        wdata_p0 <= req_wdata;
      end
      if (finish) begin
        rdata_q <= (!wr_p0 && !finish_err) ? bus.bus_rdata : '0;
`ifdef DMP_POSTED_WRITE_EN
        err_q   <= finish_err | err_sticky_q | (finish_err & posted_q);
`else
        err_q   <= finish_err;
`endif
      end
    end
  end

`ifdef DMP_POSTED_WRITE_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      posted_q     <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      if (latch_req) posted_q <= req_write;
      if (finish && finish_err && posted_q) err_sticky_q <= 1'b1;
    end
  end
`endif

  // Stall is gated by reset so an aborted transaction releases the pipeline immediately.
  assign stall         = stall_c & rst;
  assign resp_valid    = (state == DONE);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign bus.bus_req   = (state == BUS);
  assign bus.bus_we    = (state == BUS) & wr_p0;
  assign bus.bus_addr  = addr_p0;
  assign bus.bus_wdata = wdata_p0;

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Load/store bus controller directly downstream of the memory stage.
- Takes one word request per instruction from the memory stage (address = ALU result, data = forwarded B).
- Runs a req/ack handshake on the external 16-bit data bus, returns load data for the memory/writeback register, and stalls the pipeline while a transaction is outstanding.
- Replaces the direct read_in/write_out wiring at the top level.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, word address width.
- TIMEOUT, 15, maximum cycles waiting for bus_ack before abort; legal range 1..255.

Ports:
- clock  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  memory stage has a load or store this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- stall  out  1  hold pipeline (drives register write enables low).
- resp_valid  out  1  one-cycle pulse: transaction finished.
- resp_rdata  out  DATA_W  load data; valid when resp_valid.
- resp_err  out  1  transaction timed out; valid when resp_valid.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  bus write strobe.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  bus read data; sampled when bus_ack.
- bus_ack  in  1  bus completion, one cycle.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, all outputs 0, counter 0, latched request cleared. Reset mid-transaction aborts it; bus_req drops immediately and no resp_valid is produced.
- States are IDLE, BUS and DONE.
- IDLE:
  - stall = req_valid (combinational).
  - On a clock edge with req_valid=1: latch req_write, req_addr and req_wdata, clear counter, go to BUS.
- BUS:
  - bus_req=1, bus_we = latched write, bus_addr/bus_wdata = latched values; these are stable for the whole state. stall=1.
  - bus_ack=1: capture bus_rdata if load, else capture 0; resp_err=0; go to DONE.
  - No ack: counter increments. When counter == TIMEOUT-1 and no ack, go to DONE with resp_err=1 and resp_rdata=0.
  - Ack on the timeout cycle counts as success.
- DONE:
  - resp_valid=1, bus_req=0, stall=0, for exactly one cycle; then IDLE.
  - A req_valid seen in DONE is ignored, because the pipeline advances this cycle; the next instruction's request is taken in IDLE.
- Latency: load/store with ack in the first BUS cycle takes 3 cycles (IDLE edge, BUS, DONE); stall is high for 2 cycles.
- bus_ack outside BUS is ignored.
- resp_rdata and resp_err hold their value until the next DONE.
- Counter is 8 bits, saturating; it never wraps.

Optional Feature:
- Macro: DMP_POSTED_WRITE_EN.
- Defined:
  - A store in IDLE is accepted without stall (stall stays 0) into a one-entry write buffer, and a bus write is issued from the buffer.
  - resp_valid pulses when that write completes.
  - A second request (load or store) arriving while the buffer is busy asserts stall until the buffered write completes, then proceeds normally.
  - A buffered-write timeout sets a sticky resp_err, cleared only by reset.
- Undefined: stores stall exactly like loads; resp_err is per-transaction.

Test Plan:
- Load: req_valid=1, req_write=0, req_addr=0x0010; bus_ack in first BUS cycle with bus_rdata=0xBEEF -> bus_addr=0x0010, bus_we=0; stall high 2 cycles; resp_valid 1 cycle with resp_rdata=0xBEEF, resp_err=0.
- Store: req_write=1, addr 0x0020, data 0x1234, ack after 3 wait cycles -> bus_we=1, bus_wdata=0x1234 held stable for 4 BUS cycles; stall high 5 cycles; resp_rdata=0.
- Timeout: load with bus_ack never asserted, TIMEOUT=15 -> bus_req high exactly 15 cycles; resp_valid with resp_err=1, resp_rdata=0; next load with immediate ack has resp_err=0.
- Reset mid-BUS: rst low during cycle 2 of a load -> bus_req, stall and resp_valid drop to 0 asynchronously; after release, a new request behaves as the first load scenario.
- Back-to-back: load then store on consecutive instructions -> two separate BUS phases; the second request is taken only in IDLE after DONE, never in DONE.
- DMP_POSTED_WRITE_EN: store then immediate load, ack delay 2 -> stall 0 for the store, stall 1 on the load until the write acks, then normal load completion.
